fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the 4-bit-opcode processor. Maintains the PC, issues one word per cycle to the synchronous instruction memory (one-cycle read latency), and presents the fetched instruction, its PC and PC+1 to the decode stage. The decode stage's control unit consumes `ifid_opcode`. The block absorbs stalls from the hazard unit without dropping or duplicating words, and accepts jump/branch redirects from the execute stage.

## Interface
- `PC_W`, 8, PC and instruction-address width
- `INSTR_W`, 32, instruction width. Opcode is bits `[INSTR_W-1 -: 4]`.
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  hold IF/ID and the PC (load-use hazard)
- `redirect_valid`  in  1  taken jump/branch; flush and refetch
- `redirect_pc`  in  PC_W  target address
- `imem_en`  out  1  read strobe to instruction memory
- `imem_addr`  out  PC_W  read address
- `imem_rdata`  in  INSTR_W  word for the address strobed on the previous cycle
- `ifid_valid`  out  1  IF/ID holds a real instruction
- `ifid_instr`  out  INSTR_W  fetched instruction
- `ifid_opcode`  out  4  `ifid_instr` opcode field, to the control unit
- `ifid_pc`  out  PC_W  address of `ifid_instr`
- `ifid_pc_plus1`  out  PC_W  `ifid_pc + 1`, modulo 2^PC_W (SVPC/link use)

## Operation
- **Registers:**
  - `pc`: next address to issue.
  - `req_valid` and `req_pc`: a fetch is in flight and its address.
  - `buf_valid`, `buf_instr`, `buf_pc`: skid buffer.
  - IF/ID registers.
  - FSM state: RUN or HOLD.
- **Combinational outputs:**
  - `imem_addr = pc`.
  - `imem_en = rst_n & ~stall & ~redirect_valid`.
  - `ifid_opcode` and `ifid_pc_plus1` are decoded from the IF/ID registers.
- **Priority per edge:** reset > redirect > stall > normal.
- **Redirect:**
  - `pc <= redirect_pc`.
  - `req_valid`, `buf_valid` and `ifid_valid` are all cleared, and `ifid_instr <= 0` (NOP).
  - Next state is RUN. This applies in either state and regardless of `stall`.
- **RUN, no stall:**
  - Issue fetch at `pc`: `req_valid <= 1`, `req_pc <= pc`, `pc <= pc+1`.
  - IF/ID loads `{req_valid, imem_rdata, req_pc}`.
- **RUN, stall:**
  - IF/ID holds.
  - The in-flight word is captured: `buf_valid <= req_valid`, `buf_instr <= imem_rdata`, `buf_pc <= req_pc`.
  - `req_valid <= 0`; `pc` holds; go to HOLD.
- **HOLD, stall:** everything holds.
- **HOLD, no stall:**
  - IF/ID loads `{buf_valid, buf_instr, buf_pc}`, then `buf_valid <= 0`.
  - Issue fetch at `pc` exactly as in RUN; go to RUN.
- **Wrap-around:** `pc` and `ifid_pc_plus1` wrap from 2^PC_W-1 to 0.
- **Consumer rule:** downstream ignores `ifid_instr` when `ifid_valid=0`. Invalid slots always carry opcode 0000 (NOP) after reset or redirect.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n` low):
  - `pc=RESET_PC`
  - `req_valid=0`, `buf_valid=0`
  - `ifid_valid=0`, `ifid_instr=0`, `ifid_pc=0`, so `ifid_pc_plus1=1`
  - state=RUN
  - `imem_en=0` while `rst_n` is low
- **Reset mid-operation:** the in-flight fetch and the buffer are discarded; no partial state survives.
- **Startup latency:**
  - The first cycle with `rst_n` high issues `RESET_PC`.
  - `ifid_valid` rises after the 2nd rising edge, with `ifid_pc=RESET_PC`.
- **Throughput:** one instruction per cycle with no stall.
- **Redirect penalty:**
  - Redirect sampled at edge N: `ifid_valid=0` after N and N+1.
  - Target valid in IF/ID after edge N+2.
- **Stall:**
  - A stall asserted for k cycles holds IF/ID for exactly k edges.
  - The first edge with `stall` low loads the buffered word.
  - The word after it appears one edge later, so there are no bubbles beyond the stall itself.
- **`imem_rdata`** is sampled only on edges where `req_valid=1`. Any other value on it is don't-care.

## Test plan
- **Reset/startup:** mem[i]=0x4000_0000+i, `RESET_PC=0`, release reset → `imem_addr` 0,1,2…; after edge 2: `ifid_valid=1`, `ifid_pc=0`, `ifid_instr=0x4000_0000`, `ifid_opcode=4'b0100`; then `ifid_pc` increments by 1 per edge.
- **Stall:**
  - Stimulus: assert `stall` for 3 cycles while `ifid_pc=4`.
  - Response: IF/ID holds pc 4 for 3 edges, `imem_en=0` during the stall, then `ifid_pc`=5,6,7 on consecutive edges, with no drop or duplicate.
- **Redirect:** `redirect_valid=1`, `redirect_pc=0x20` for one cycle → `ifid_valid=0` for 2 edges, then `ifid_pc=0x20`, `ifid_instr`=mem[0x20].
- **Simultaneous events:**
  - Redirect to 0x40 with `stall=1` in the same cycle, and also redirect while in HOLD: the buffer is discarded, next state is RUN, and `ifid_pc=0x40` two edges after `stall` drops.
  - Reset asserted in HOLD: all outputs return to reset values immediately.
- **Wrap:**
  - Stimulus: `PC_W=8`, redirect to 0xFE.
  - Response: `ifid_pc` runs 0xFE, 0xFF, 0x00; `ifid_pc_plus1=0x00` when `ifid_pc=0xFF`.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC and one-cycle-latency instruction fetch with a stall skid buffer,
// feeding the IF/ID pipeline register.
module fetch_stage #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 32,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [3:0]         ifid_opcode,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc_plus1
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    logic [0:0]         state;
    logic [PC_W-1:0]    pc, req_pc, buf_pc;
    logic               req_valid, buf_valid;
    logic [INSTR_W-1:0] buf_instr, fetched;
    // Invalid slots must carry a NOP, so memory data is only taken for real fetches.
    assign fetched       = req_valid ? imem_rdata : '0;
    assign imem_en       = rst_n & ~stall & ~redirect_valid;
    assign imem_addr     = pc;
    assign ifid_opcode   = ifid_instr[INSTR_W-1 -: 4];
    assign ifid_pc_plus1 = ifid_pc + PC_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= PC_W'(RESET_PC);
            req_valid  <= 1'b0;
            req_pc     <= '0;
            buf_valid  <= 1'b0;
            buf_instr  <= '0;
            buf_pc     <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            state      <= RUN;
        end else if (redirect_valid) begin
            pc         <= redirect_pc;
            req_valid  <= 1'b0;
            buf_valid  <= 1'b0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            state      <= RUN;
        end else if (stall) begin
            if (state == RUN) begin
                buf_valid <= req_valid;
                buf_instr <= fetched;
                buf_pc    <= req_pc;
                req_valid <= 1'b0;
                state     <= HOLD;
            end
        end else begin
            req_valid  <= 1'b1;
            req_pc     <= pc;
            pc         <= pc + PC_W'(1);
            ifid_valid <= (state == HOLD) ? buf_valid : req_valid;
            ifid_instr <= (state == HOLD) ? buf_instr : fetched;
            ifid_pc    <= (state == HOLD) ? buf_pc : req_pc;
            buf_valid  <= 1'b0;
            state      <= RUN;
        end
    end
endmodule
